spi_target: RTL and testbench

//  SPI responder (slave) for the SPI master on IO words 4/5: mode 0, MSB first,
//  8-bit (slow) or 32-bit (fast) words. Oversamples SCLK/MOSI/SS in the system

---
 rtl/spi_target.sv | 195 +++++++++++++++++++
 tb/tb_spi_target.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// spi_target -- SPI responder (mode 0, MSB first, 8- or 32-bit words).
//
// SCLK, MOSI and SS are oversampled in the clk domain through SYNC flops.
// Edges on the synchronised SCLK/SS drive the word engine. One word is
// shifted in on MOSI and one out on MISO per transfer. Received words go to
// the host through a rdy/done handshake, and the next word to send is written
// through a load/txrdy handshake. Several words may be sent back to back
// while SS stays low.
//
// Optional feature macro: SPI_TARGET_OVERRUN_EN
//   defined   : adds output ovr. It is set when a word completes while rdy is
//               still pending and done is not asserted. The old dataRx is kept.
//   undefined : no ovr port. A completed word always overwrites dataRx.
//
// Parameters:
//   SYNC      synchroniser depth on SCLK/MOSI/SS (>= 2)
//   IDLEMISO  MISO level while SS is deasserted
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   SCLK       SPI clock from the master (idle low)
//   MOSI       serial data from the master
//   SS         slave select, active low
//   MISO       serial data to the master (registered)
//   fast       word size select (0: 8 bits, 1: 32 bits), sampled when SS falls
//   dataTx     next word to transmit
//   load       1-clk strobe that captures dataTx into the holding register
//   txrdy      holding register empty
//   dataRx     last received word (zero-extended in 8-bit mode)
//   rdy        dataRx valid and not yet consumed
//   done       1-clk strobe from the host that consumes dataRx
//   ovr        (SPI_TARGET_OVERRUN_EN only) overrun flag
module spi_target #(
  parameter int   SYNC     = 2,
  parameter logic IDLEMISO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS,
  output logic        MISO,
  input  logic        fast,
  input  logic [31:0] dataTx,
  input  logic        load,
  output logic        txrdy,
  output logic [31:0] dataRx,
  output logic        rdy,
  input  logic        done
`ifdef SPI_TARGET_OVERRUN_EN
  ,
  output logic        ovr
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state;
  logic [SYNC-1:0] sclkSync;
  logic [SYNC-1:0] mosiSync;
  logic [SYNC-1:0] ssSync;
  logic            sclkPrev;
  logic            ssPrev;
  logic            sclkS;
  logic            mosiS;
  logic            ssS;
  logic            sclkRise;
  logic            sclkFall;
  logic            ssFall;
  logic            ssRise;
  logic [31:0]     hold;
  logic [31:0]     shift;
  logic [31:0]     reloadWord;
  logic [31:0]     rxWord;
  logic [5:0]      bitCnt;
  logic [5:0]      lastBit;
  logic            rxBit;
  logic            wsel;

  assign sclkS    = sclkSync[SYNC-1];
  assign mosiS    = mosiSync[SYNC-1];
  assign ssS      = ssSync[SYNC-1];
  assign sclkRise = sclkS & ~sclkPrev;
  assign sclkFall = ~sclkS & sclkPrev;
  assign ssFall   = ~ssS & ssPrev;
  assign ssRise   = ssS & ~ssPrev;

  // An empty holding register sends zeros. The received word is assembled
  // from the bits already shifted in plus the bit arriving on this rise.
  assign reloadWord = txrdy ? 32'd0 : hold;
  assign lastBit    = wsel ? 6'd31 : 6'd7;
  assign rxWord     = wsel ? {shift[30:0], mosiS} : {24'd0, shift[6:0], mosiS};

  // Synchroniser chains for the asynchronous SPI pins. Each chain also keeps
  // one delayed copy of its output for edge detection. The chains reset to
  // the idle bus levels (SCLK low, SS high) so that leaving reset does not
  // look like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclkSync <= '0;
      mosiSync <= '0;
      ssSync   <= '1;
      sclkPrev <= 1'b0;
      ssPrev   <= 1'b1;
    end else begin
      sclkSync <= {sclkSync[SYNC-2:0], SCLK};
      mosiSync <= {mosiSync[SYNC-2:0], MOSI};
      ssSync   <= {ssSync[SYNC-2:0], SS};
      sclkPrev <= sclkS;
      ssPrev   <= ssS;
    end
  end

  // Word engine and host handshake.
  // A rise captures MOSI into rxBit. The following fall shifts that bit in at
  // the LSB and presents the next transmit bit. The transmit LSB therefore
  // stays intact until it is sent. A fall that follows a word end (bitCnt == 0)
  // must not shift, because the register was just reloaded with the next word.
  // A load is processed last so that a load in the same clk as a reload is not
  // lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      MISO   <= IDLEMISO;
      txrdy  <= 1'b1;
      dataRx <= 32'd0;
      rdy    <= 1'b0;
      hold   <= 32'd0;
      shift  <= 32'd0;
      bitCnt <= 6'd0;
      rxBit  <= 1'b0;
      wsel   <= 1'b0;
`ifdef SPI_TARGET_OVERRUN_EN
      ovr    <= 1'b0;
`endif
    end else begin
      if (done) begin
        rdy <= 1'b0;
`ifdef SPI_TARGET_OVERRUN_EN
        ovr <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (ssFall) begin
            state  <= ACTIVE;
            wsel   <= fast;
            shift  <= reloadWord;
            txrdy  <= 1'b1;
            bitCnt <= 6'd0;
            MISO   <= fast ? reloadWord[31] : reloadWord[7];
          end
        end
        ACTIVE: begin
          if (ssRise) begin
            state  <= IDLE;
            bitCnt <= 6'd0;
            MISO   <= IDLEMISO;
          end else if (sclkRise) begin
            rxBit <= mosiS;
            if (bitCnt == lastBit) begin
              bitCnt <= 6'd0;
              rdy    <= 1'b1;
`ifdef SPI_TARGET_OVERRUN_EN
              if (rdy && !done) begin
                ovr <= 1'b1;
              end else begin
                dataRx <= rxWord;
              end
`else
              dataRx <= rxWord;
`endif
              shift <= reloadWord;
              txrdy <= 1'b1;
              MISO  <= wsel ? reloadWord[31] : reloadWord[7];
            end else begin
              bitCnt <= bitCnt + 6'd1;
            end
          end else if (sclkFall && bitCnt != 6'd0) begin
            shift <= {shift[30:0], rxBit};
            MISO  <= wsel ? shift[30] : shift[6];
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        hold  <= dataTx;
        txrdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target -- directed bench for spi_target. The bench acts as the SPI
// master and the host, and checks every result against hand-computed values.
module tb_spi_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        SS = 1'b1;
  logic        MISO;
  logic        fast = 1'b0;
  logic [31:0] dataTx = 32'd0;
  logic        load = 1'b0;
  logic        txrdy;
  logic [31:0] dataRx;
  logic        rdy;
  logic        done = 1'b0;
`ifdef SPI_TARGET_OVERRUN_EN
  logic        ovr;
`endif

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] got;
  logic [31:0] got2;

  spi_target #(.SYNC(2), .IDLEMISO(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .SS(SS),
    .MISO(MISO),
    .fast(fast),
    .dataTx(dataTx),
    .load(load),
    .txrdy(txrdy),
    .dataRx(dataRx),
    .rdy(rdy),
    .done(done)
`ifdef SPI_TARGET_OVERRUN_EN
    ,
    .ovr(ovr)
`endif
  );

  // 25 MHz system clock
  always #20 clk = ~clk;

  // Wait for a number of falling clk edges. Inputs are driven and outputs
  // are sampled on those edges.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hostLoad(input logic [31:0] w);
    dataTx = w;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic hostDone();
    done = 1'b1;
    tick(1);
    done = 1'b0;
  endtask

  task automatic selectTarget();
    SS = 1'b0;
    tick(6);
  endtask

  task automatic releaseTarget();
    tick(4);
    SS = 1'b1;
    tick(6);
  endtask

  // Shift nbits of w (MSB first) with 4-clk SCLK phases and return the
  // MISO bits seen just before each rise. After the last rise the bench can
  // check the rdy latency, and it can pulse done in the word-end clk.
  task automatic applyStimulus(input int nbits, input logic [31:0] w, input bit checkLat,
                               input bit doneAtEnd, output logic [31:0] misoWord);
    misoWord = 32'd0;
    for (int i = nbits - 1; i >= 0; i--) begin
      MOSI = w[i];
      tick(4);
      misoWord[i] = MISO;
      SCLK = 1'b1;
      if (i == 0) begin
        tick(2);
        if (checkLat) checkOutput("rdy_before_latency", {31'd0, rdy}, 32'd0);
        if (doneAtEnd) done = 1'b1;
        tick(1);
        done = 1'b0;
        if (checkLat) checkOutput("rdy_at_latency", {31'd0, rdy}, 32'd1);
        tick(1);
      end else begin
        tick(4);
      end
      SCLK = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] keepRx;

    // Reset state
    tick(3);
    checkOutput("reset_miso", {31'd0, MISO}, 32'd1);
    checkOutput("reset_txrdy", {31'd0, txrdy}, 32'd1);
    checkOutput("reset_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("reset_dataRx", dataRx, 32'd0);
    rst = 1'b0;
    tick(2);

    // Test 1: 8-bit transfer with a loaded word
    fast = 1'b0;
    hostLoad(32'h0000_00A5);
    checkOutput("t1_txrdy_after_load", {31'd0, txrdy}, 32'd0);
    selectTarget();
    checkOutput("t1_txrdy_after_ss", {31'd0, txrdy}, 32'd1);
    applyStimulus(8, 32'h3C, 1'b0, 1'b0, got);
    releaseTarget();
    checkOutput("t1_miso", got, 32'h0000_00A5);
    checkOutput("t1_dataRx", dataRx, 32'h0000_003C);
    checkOutput("t1_rdy", {31'd0, rdy}, 32'd1);
    checkOutput("t1_miso_idle", {31'd0, MISO}, 32'd1);
    hostDone();
    checkOutput("t1_rdy_after_done", {31'd0, rdy}, 32'd0);

    // Test 2: 32-bit transfer and exact rdy latency
    fast = 1'b1;
    hostLoad(32'hDEAD_BEEF);
    selectTarget();
    applyStimulus(32, 32'h1234_5678, 1'b1, 1'b0, got);
    releaseTarget();
    checkOutput("t2_miso", got, 32'hDEAD_BEEF);
    checkOutput("t2_dataRx", dataRx, 32'h1234_5678);
    hostDone();

    // Test 3: two back-to-back 8-bit words without a load
    fast = 1'b0;
    selectTarget();
    applyStimulus(8, 32'h01, 1'b0, 1'b0, got);
    applyStimulus(8, 32'h02, 1'b0, 1'b0, got2);
    releaseTarget();
    checkOutput("t3_miso_w0", got, 32'd0);
    checkOutput("t3_miso_w1", got2, 32'd0);
    checkOutput("t3_rdy", {31'd0, rdy}, 32'd1);
`ifdef SPI_TARGET_OVERRUN_EN
    keepRx = 32'h01;
    checkOutput("t3_ovr", {31'd0, ovr}, 32'd1);
`else
    keepRx = 32'h02;
`endif
    checkOutput("t3_dataRx", dataRx, keepRx);
    hostDone();
    checkOutput("t3_rdy_after_done", {31'd0, rdy}, 32'd0);

    // Test 4: SS raised after 5 bits, then a full word
    selectTarget();
    applyStimulus(5, 32'h1F, 1'b0, 1'b0, got);
    releaseTarget();
    checkOutput("t4_rdy_partial", {31'd0, rdy}, 32'd0);
    checkOutput("t4_dataRx_partial", dataRx, keepRx);
    checkOutput("t4_miso_idle", {31'd0, MISO}, 32'd1);
    selectTarget();
    applyStimulus(8, 32'hC3, 1'b0, 1'b0, got);
    releaseTarget();
    checkOutput("t4_dataRx", dataRx, 32'h0000_00C3);
    checkOutput("t4_rdy", {31'd0, rdy}, 32'd1);
    checkOutput("t4_miso", got, 32'd0);

    // Test 5: done in the same clk as word end; the word end wins
    selectTarget();
    applyStimulus(8, 32'h5A, 1'b0, 1'b1, got);
    releaseTarget();
    checkOutput("t5_rdy", {31'd0, rdy}, 32'd1);
    checkOutput("t5_dataRx", dataRx, 32'h0000_005A);
`ifdef SPI_TARGET_OVERRUN_EN
    checkOutput("t5_ovr", {31'd0, ovr}, 32'd0);
`endif
    hostDone();

    // Test 6: reset in the middle of a 32-bit word, then a normal transfer
    fast = 1'b1;
    hostLoad(32'h0F0F_0F0F);
    selectTarget();
    applyStimulus(12, 32'hABC, 1'b0, 1'b0, got);
    rst = 1'b1;
    tick(1);
    checkOutput("t6_reset_miso", {31'd0, MISO}, 32'd1);
    checkOutput("t6_reset_txrdy", {31'd0, txrdy}, 32'd1);
    checkOutput("t6_reset_dataRx", dataRx, 32'd0);
    checkOutput("t6_reset_rdy", {31'd0, rdy}, 32'd0);
    SS = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(2);
    hostLoad(32'hCAFE_F00D);
    selectTarget();
    applyStimulus(32, 32'h8765_4321, 1'b0, 1'b0, got);
    releaseTarget();
    checkOutput("t6_miso", got, 32'hCAFE_F00D);
    checkOutput("t6_dataRx", dataRx, 32'h8765_4321);
    checkOutput("t6_rdy", {31'd0, rdy}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
